// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam logic [3:0] MDU_none  = 4'd0;
    localparam logic [3:0] MDU_mult  = 4'd1;
    localparam logic [3:0] MDU_multu = 4'd2;
    localparam logic [3:0] MDU_div   = 4'd3;
    localparam logic [3:0] MDU_divu  = 4'd4;
    localparam logic [3:0] MDU_mfhi  = 4'd5;
    localparam logic [3:0] MDU_mflo  = 4'd6;
    localparam logic [3:0] MDU_mthi  = 4'd7;
    localparam logic [3:0] MDU_mtlo  = 4'd8;
    localparam logic [3:0] MDU_madd  = 4'd9;
    localparam logic [3:0] MDU_maddu = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Ops that take the multiplier latency.
    function automatic logic is_mult_class(input logic [3:0] op);
        logic r;
        r = (op == MDU_mult) || (op == MDU_multu);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_madd) || (op == MDU_maddu);
`endif
        return r;
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_mult_class(op) || (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit with HI/LO registers, busy flag and MFHI/MFLO read port.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] MDUOut,
    output mdu_state_t  dbg_state
);

    mdu_state_t  state;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign quo_s  = $signed(a_q) / $signed(b_q);
    assign rem_s  = $signed(a_q) % $signed(b_q);

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_we = 1'b0;
        case (op_q)
            MDU_mult: begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            MDU_multu: begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            MDU_div: begin
                // A zero divisor leaves HI/LO untouched.
                if (b_q != 32'd0) begin
                    res_lo = quo_s;
                    res_hi = rem_s;
                    res_we = 1'b1;
                end
            end
            MDU_divu: begin
                if (b_q != 32'd0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                    res_we = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            MDU_madd: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
                res_we = 1'b1;
            end
            MDU_maddu: begin
                {res_hi, res_lo} = {hi, lo} + prod_u;
                res_we = 1'b1;
            end
`endif
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            op_q  <= MDU_none;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long_op(MDUOp)) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= MDUOp;
                            cnt   <= is_mult_class(MDUOp) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= ST_BUSY;
                        end else if (MDUOp == MDU_mthi) begin
                            hi <= A;
                        end else if (MDUOp == MDU_mtlo) begin
                            lo <= A;
                        end
                    end
                end
                ST_BUSY: begin
                    // start is deliberately not looked at here.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (MDUOp)
            MDU_mfhi: MDUOut = hi;
            MDU_mflo: MDUOut = lo;
            default:  MDUOut = 32'd0;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mdu.sv
// Randomized scoreboard bench for mdu: driver tasks push expected HI/LO reads and busy
// lengths from a plain-arithmetic model; a negedge monitor pops and compares.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] MDUOut;
    mdu_state_t  dbg_state;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .MDUOut(MDUOut), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_rd = 1'b0;
    logic        mon_obs = 1'b0;
    logic [31:0] obs_val = 32'd0;
    logic        done = 1'b0;
    logic        reported = 1'b0;
    logic [31:0] mon_got;
    logic [31:0] mon_exp;
    string       mon_tag;

    // Reference HI/LO as the architecture defines them.
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always @(negedge clk) begin
        if (mon_rd || mon_obs) begin
            mon_got = mon_rd ? MDUOut : obs_val;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL underrun: got %h with nothing expected", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", mon_tag, mon_got, mon_exp);
                end
            end
        end
        if (done && !reported) begin
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL leftover: got %0d pending expectations expected 0", exp_q.size());
            end
            reported = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_obs(input string tag, input logic [31:0] got, input logic [31:0] exp);
        obs_val = got;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        mon_obs = 1'b1;
        cycle();
        mon_obs = 1'b0;
    endtask

    task automatic expect_hilo(input string tag);
        MDUOp = MDU_mfhi;
        exp_q.push_back(model_hi);
        tag_q.push_back({tag, "_hi"});
        mon_rd = 1'b1;
        cycle();
        MDUOp = MDU_mflo;
        exp_q.push_back(model_lo);
        tag_q.push_back({tag, "_lo"});
        cycle();
        mon_rd = 1'b0;
        MDUOp = MDU_none;
    endtask

    task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        cycle();
        start = 1'b0;
        MDUOp = MDU_none;
        A = $urandom;
        B = $urandom;
    endtask

    // Single-cycle or ignored ops: model update plus a busy-stays-low check.
    task automatic run_short(input logic [3:0] op, input logic [31:0] a, input string tag);
        do_start(op, a, $urandom);
        if (op == MDU_mthi) model_hi = a;
        if (op == MDU_mtlo) model_lo = a;
        expect_obs({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // mode 0: quiet, 1: read HI every busy cycle, 2: toggle operands and pulse MTLO while busy.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int mode, input string tag);
        int          n_exp;
        int          n;
        int          ia;
        int          ib;
        logic [63:0] acc;
        logic [63:0] ps;
        logic [63:0] pu;
        ia = a;
        ib = b;
        ps = longint'(ia) * longint'(ib);
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        acc = {model_hi, model_lo};
        n_exp = 0;
        case (op)
            MDU_mult:  begin n_exp = MULT_N; acc = ps; end
            MDU_multu: begin n_exp = MULT_N; acc = pu; end
            MDU_div:   begin n_exp = DIV_N; if (b != 0) acc = {32'(ia % ib), 32'(ia / ib)}; end
            MDU_divu:  begin n_exp = DIV_N; if (b != 0) acc = {a % b, a / b}; end
`ifdef MDU_MADD_EN
            MDU_madd:  begin n_exp = MULT_N; acc = acc + ps; end
            MDU_maddu: begin n_exp = MULT_N; acc = acc + pu; end
`endif
            default:   n_exp = 0;
        endcase
        do_start(op, a, b);
        n = 0;
        while (busy && n < 40) begin
            if (mode == 1) begin
                MDUOp = MDU_mfhi;
                exp_q.push_back(model_hi);
                tag_q.push_back({tag, "_peek_hi"});
                mon_rd = 1'b1;
            end else if (mode == 2) begin
                A = $urandom;
                B = $urandom;
                start = 1'b1;
                MDUOp = MDU_mtlo;
            end
            cycle();
            n++;
        end
        start = 1'b0;
        mon_rd = 1'b0;
        MDUOp = MDU_none;
        {model_hi, model_lo} = acc;
        expect_obs({tag, "_busy_len"}, 32'(n), 32'(n_exp));
        expect_hilo(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        MDUOp = MDU_none;
        A = 32'd0;
        B = 32'd0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        expect_obs("reset_busy", {31'd0, busy}, 32'd0);
        expect_hilo("reset");

        run_long(MDU_mult,  32'hFFFF_FFFE, 32'd3, 0, "mult_neg");
        run_long(MDU_multu, 32'hFFFF_FFFF, 32'd2, 0, "multu");
        run_long(MDU_div,   32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        run_long(MDU_divu,  32'd7,         32'd2, 0, "divu");

        run_short(MDU_mthi, 32'h0000_1234, "mthi");
        run_short(MDU_mtlo, 32'h0000_5678, "mtlo");
        run_long(MDU_divu,  32'd99, 32'd0, 1, "divu_by0");
        run_long(MDU_div,   32'h8000_0005, 32'd0, 0, "div_by0");

        run_long(MDU_mult,  32'd3, 32'd4, 2, "mult_chaos");

        // Ops that must not change state.
        run_short(MDU_none, $urandom, "start_none");
        run_short(MDU_mfhi, $urandom, "start_mfhi");
        run_short(MDU_mflo, $urandom, "start_mflo");
        run_short(4'd13,    $urandom, "start_op13");
        expect_hilo("after_noops");

        // Reset in the third busy cycle of a divide.
        do_start(MDU_div, 32'd100, 32'd7);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        expect_obs("midop_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        expect_hilo("midop_rst");
        run_long(MDU_mult, 32'd2, 32'd2, 0, "mult_after_rst");

        // Accumulate: carries out of LO into HI when enabled, no effect otherwise.
        run_short(MDU_mthi, 32'd0, "madd_mthi");
        run_short(MDU_mtlo, 32'hFFFF_FFFF, "madd_mtlo");
        run_long(MDU_maddu, 32'd1, 32'd1, 0, "maddu");
        run_long(MDU_madd,  32'hFFFF_FFFF, 32'd5, 0, "madd_neg");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            case ($urandom_range(0, 7))
                0: op = MDU_mult;
                1: op = MDU_multu;
                2: op = MDU_div;
                3: op = MDU_divu;
                4: op = MDU_mthi;
                5: op = MDU_mtlo;
                6: op = MDU_madd;
                default: op = MDU_maddu;
            endcase
            // The signed overflow quotient is architecturally undefined; keep it out.
            if (op == MDU_div && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            if (op == MDU_mthi || op == MDU_mtlo) begin
                run_short(op, ra, "rand_mt");
                expect_hilo("rand_mt");
            end else begin
                run_long(op, ra, rb, int'($urandom_range(0, 2)), "rand_op");
            end
        end

        done = 1'b1;
        for (int k = 0; k < 5 && !reported; k++) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
